// File: rtl/morse_pkg.sv
// Shared Morse digit definitions: FSM states, element durations in units,
// and the digit-to-pattern table used by both the transmitter and decoder.
package morse_pkg;

    // Transmit scheduler states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        GAP,
        CGAP
    } morse_state_e;

    // Element durations in Morse time units
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int EGAP_UNITS = 1;
    localparam int CGAP_UNITS = 3;

    // Five-element pattern, MSB is sent first, 1 = dash, 0 = dot
    typedef struct packed {
        logic       valid;
        logic [4:0] pattern;
    } morse_code_t;

    function automatic morse_code_t digit_to_pattern(input logic [3:0] digit);
        morse_code_t code;
        code.valid = 1'b1;
        case (digit)
            4'd0:    code.pattern = 5'b11111;
            4'd1:    code.pattern = 5'b01111;
            4'd2:    code.pattern = 5'b00111;
            4'd3:    code.pattern = 5'b00011;
            4'd4:    code.pattern = 5'b00001;
            4'd5:    code.pattern = 5'b00000;
            4'd6:    code.pattern = 5'b10000;
            4'd7:    code.pattern = 5'b11000;
            4'd8:    code.pattern = 5'b11100;
            4'd9:    code.pattern = 5'b11110;
            default: begin
                code.valid   = 1'b0;
                code.pattern = 5'b00000;
            end
        endcase
        return code;
    endfunction

    function automatic logic digit_is_legal(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

endpackage

// File: rtl/morse_digit_fifo.sv
// Four-entry, four-bit synchronous digit FIFO with asynchronous active-low
// reset. Head entry is presented combinationally on data_o.
module morse_digit_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    logic [3:0] mem_q [4];
    logic [1:0] wrPtr_q;
    logic [1:0] rdPtr_q;
    logic [2:0] count_q;
    logic       doPush;
    logic       doPop;

    assign full_o  = (count_q == 3'd4);
    assign empty_o = (count_q == 3'd0);
    assign data_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Storage, pointers and occupancy, all cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'd0;
            end
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
            count_q <= 3'd0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 2'd1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, doPush} - {2'b00, doPop};
        end
    end

endmodule

// File: rtl/morse_digit_tx.sv
// Morse digit transmitter: accepts decimal digits over valid/ready and
// plays each one out on the registered mors line as five dot/dash marks.
// Optional feature macro MORSE_DIGIT_TX_FIFO_EN adds a 4-entry digit FIFO;
// without it a single holding register is used and input stalls while busy.
module morse_digit_tx
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    output logic       mors,
    output logic       busy,
    output logic       err
);
    localparam logic [7:0] CYC_LAST  = 8'(UNIT_CYCLES - 1);
    localparam logic [1:0] DOT_LAST  = 2'(DOT_UNITS - 1);
    localparam logic [1:0] DASH_LAST = 2'(DASH_UNITS - 1);
    localparam logic [1:0] EGAP_LAST = 2'(EGAP_UNITS - 1);
    localparam logic [1:0] CGAP_LAST = 2'(CGAP_UNITS - 1);

    morse_state_e state_q, state_d;
    logic [7:0]   cycCnt_q, cycCnt_d;
    logic [1:0]   unitCnt_q, unitCnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [4:0]   pat_q, pat_d;
    logic [3:0]   hold_q, hold_d;
    logic         rdyEn_q;
    logic         mors_q;
    logic         err_q;

    logic         xfer;
    logic         legalXfer;
    logic         illegalXfer;
    logic         unitTick;
    logic         phaseDone;
    logic         curDash;
    logic [1:0]   lastUnit;
    morse_code_t  loadCode;

`ifdef MORSE_DIGIT_TX_FIFO_EN
    logic         fifoPush;
    logic         fifoPop;
    logic         fifoFull;
    logic         fifoEmpty;
    logic [3:0]   fifoData;
    logic         takeNow;

    morse_digit_fifo uFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  (in_digit),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign in_ready = rdyEn_q && !fifoFull;
    assign busy     = (state_q != IDLE) || !fifoEmpty;
`else
    assign in_ready = rdyEn_q && (state_q == IDLE);
    assign busy     = (state_q != IDLE);
`endif

    assign xfer        = in_valid && in_ready;
    assign legalXfer   = xfer && digit_is_legal(in_digit);
    assign illegalXfer = xfer && !digit_is_legal(in_digit);
    assign unitTick    = (cycCnt_q == CYC_LAST);
    assign curDash     = pat_q[3'd4 - idx_q];
    assign phaseDone   = unitTick && (unitCnt_q == lastUnit);
    assign mors        = mors_q;
    assign err         = err_q;

    // Length of the current phase, expressed as its last unit index
    always_comb begin
        lastUnit = 2'd0;
        case (state_q)
            MARK:    lastUnit = curDash ? DASH_LAST : DOT_LAST;
            GAP:     lastUnit = EGAP_LAST;
            CGAP:    lastUnit = CGAP_LAST;
            default: lastUnit = 2'd0;
        endcase
    end

    // Sequencing: pick up digits, walk the five elements, then the character gap
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        hold_d   = hold_q;
        loadCode = digit_to_pattern(hold_q);
`ifdef MORSE_DIGIT_TX_FIFO_EN
        fifoPop  = 1'b0;
        takeNow  = (state_q == IDLE) || ((state_q == CGAP) && phaseDone);
        fifoPush = legalXfer && !(takeNow && fifoEmpty);
`endif
        case (state_q)
            IDLE: begin
                if (legalXfer) begin
                    hold_d  = in_digit;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pat_d   = loadCode.valid ? loadCode.pattern : 5'b00000;
                idx_d   = 3'd0;
                state_d = MARK;
            end
            MARK: begin
                if (phaseDone) begin
                    state_d = (idx_q == 3'd4) ? CGAP : GAP;
                end
            end
            GAP: begin
                if (phaseDone) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = MARK;
                end
            end
            CGAP: begin
                if (phaseDone) begin
`ifdef MORSE_DIGIT_TX_FIFO_EN
                    if (!fifoEmpty) begin
                        hold_d  = fifoData;
                        fifoPop = 1'b1;
                        state_d = LOAD;
                    end else if (legalXfer) begin
                        hold_d  = in_digit;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycle and unit timers restart on every state entry so phases are exact
    always_comb begin
        cycCnt_d  = cycCnt_q;
        unitCnt_d = unitCnt_q;
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cycCnt_d  = 8'd0;
            unitCnt_d = 2'd0;
        end else if (unitTick) begin
            cycCnt_d  = 8'd0;
            unitCnt_d = unitCnt_q + 2'd1;
        end else begin
            cycCnt_d = cycCnt_q + 8'd1;
        end
    end

    // State, timers, latched pattern and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cycCnt_q  <= 8'd0;
            unitCnt_q <= 2'd0;
            idx_q     <= 3'd0;
            pat_q     <= 5'd0;
            hold_q    <= 4'd0;
            rdyEn_q   <= 1'b0;
            mors_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycCnt_q  <= cycCnt_d;
            unitCnt_q <= unitCnt_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            hold_q    <= hold_d;
            rdyEn_q   <= 1'b1;
            mors_q    <= (state_q == MARK);
            err_q     <= illegalXfer;
        end
    end

endmodule
